// File: rtl/c17_bist_array_if.sv
`default_nettype none
// ============================================================================
// Module   : c17_bist_array_if
// Brief    : Run-control and result bundle for the c17 BIST array.
//            master = run controller, slave = c17_bist_array.
// Revision : 1.0 - initial release
// ============================================================================
interface c17_bist_array_if #(
    parameter int MISR_W = 16
);
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;
    logic [15:0]       pat_cnt;

    modport master (
        output start,
        input  busy,
        input  done,
        input  pass,
        input  signature,
        input  pat_cnt
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output pass,
        output signature,
        output pat_cnt
    );
endinterface
`default_nettype wire

// File: rtl/c17_bist_array.sv
`default_nettype none
// ============================================================================
// Module   : c17_bist_array
// Brief    : Self-testing array of ISCAS-85 c17 instances. A Galois LFSR
//            feeds every channel, a Galois MISR compacts every response over
//            PATTERNS cycles; the signature is compared against GOLDEN.
//            Optional macro C17_FAULT_INJ_EN adds port inj_en, which forces
//            channel 0 net N11 stuck-at-1 while high.
// Revision : 1.0 - initial release
// ============================================================================
module c17_bist_array #(
    parameter int                 CHANNELS  = 4,
    parameter int                 LFSR_W    = 32,
    parameter logic [LFSR_W-1:0]  LFSR_POLY = 32'h80200003,
    parameter logic [LFSR_W-1:0]  SEED      = 32'h0000ACE1,
    parameter int                 MISR_W    = 16,
    parameter logic [MISR_W-1:0]  MISR_POLY = 16'hB400,
    parameter int                 PATTERNS  = 255,
    parameter logic [MISR_W-1:0]  GOLDEN    = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    c17_bist_array_if.slave   bus
`ifdef C17_FAULT_INJ_EN
    ,
    input  logic              inj_en
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] c_SEED = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [15:0]       c_LAST = 16'(PATTERNS - 1);

    logic [1:0]          r_state;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [MISR_W-1:0]   r_misr;
    logic [15:0]         r_pat_cnt;

    logic                w_inj;
    logic [2*CHANNELS-1:0] w_ch_out;
    logic [MISR_W-1:0]   w_resp;
    logic [LFSR_W-1:0]   w_lfsr_next;
    logic [MISR_W-1:0]   w_misr_next;

`ifdef C17_FAULT_INJ_EN
    assign w_inj = inj_en;
`else
    assign w_inj = 1'b0;
`endif

    // One c17 netlist per channel, fed from its own 5-bit slice of the LFSR.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic w_n1, w_n2, w_n3, w_n6, w_n7;
        logic w_n10, w_n11, w_n16, w_n19;
        assign w_n1  = r_lfsr[5*k];
        assign w_n2  = r_lfsr[5*k+1];
        assign w_n3  = r_lfsr[5*k+2];
        assign w_n6  = r_lfsr[5*k+3];
        assign w_n7  = r_lfsr[5*k+4];
        assign w_n10 = ~(w_n1 & w_n3);
        // Only channel 0 carries the stuck-at-1 fault site.
        assign w_n11 = ~(w_n3 & w_n6) | ((k == 0) & w_inj);
        assign w_n16 = ~(w_n2 & w_n11);
        assign w_n19 = ~(w_n11 & w_n7);
        assign w_ch_out[2*k]   = ~(w_n10 & w_n16);
        assign w_ch_out[2*k+1] = ~(w_n16 & w_n19);
    end

    // Pack channel outputs into the low bits of the response; upper bits stay 0.
    always_comb begin
        w_resp = '0;
        w_resp[2*CHANNELS-1:0] = w_ch_out;
    end

    // Galois steps for the pattern generator and the signature register.
    always_comb begin
        w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_POLY) : (r_lfsr >> 1);
        w_misr_next = (r_misr[0] ? ((r_misr >> 1) ^ MISR_POLY) : (r_misr >> 1)) ^ w_resp;
    end

    // Run control: reload on accepted start, compact one pattern per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_lfsr    <= c_SEED;
            r_misr    <= '0;
            r_pat_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (bus.start) begin
                        r_state   <= c_RUN;
                        r_lfsr    <= c_SEED;
                        r_misr    <= '0;
                        r_pat_cnt <= '0;
                    end
                end
                c_RUN: begin
                    r_misr    <= w_misr_next;
                    r_lfsr    <= w_lfsr_next;
                    r_pat_cnt <= r_pat_cnt + 16'd1;
                    if (r_pat_cnt == c_LAST) begin
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state == c_RUN);
    assign bus.done      = (r_state == c_DONE);
    assign bus.pass      = (r_state == c_DONE) && (r_misr == GOLDEN);
    assign bus.signature = r_misr;
    assign bus.pat_cnt   = r_pat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_c17_bist_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_c17_bist_array
// Brief    : Directed self-checking bench for c17_bist_array. Three instances
//            cover the default build and two single-channel, single-pattern
//            configurations with hand-derived signatures.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c17_bist_array;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inj0 = 1'b0;
    logic inj1 = 1'b0;
    logic inj2 = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    c17_bist_array_if #(.MISR_W(16)) u_if0 ();
    c17_bist_array_if #(.MISR_W(16)) u_if1 ();
    c17_bist_array_if #(.MISR_W(16)) u_if2 ();

    c17_bist_array u_dut0 (
        .clk    (clk),
        .rst    (rst),
        .bus    (u_if0)
`ifdef C17_FAULT_INJ_EN
        ,
        .inj_en (inj0)
`endif
    );

    c17_bist_array #(
        .CHANNELS (1),
        .SEED     (32'h0000001F),
        .PATTERNS (1),
        .GOLDEN   (16'h0001)
    ) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .bus    (u_if1)
`ifdef C17_FAULT_INJ_EN
        ,
        .inj_en (inj1)
`endif
    );

    c17_bist_array #(
        .CHANNELS (1),
        .SEED     (32'h00000001),
        .PATTERNS (1),
        .GOLDEN   (16'h0000)
    ) u_dut2 (
        .clk    (clk),
        .rst    (rst),
        .bus    (u_if2)
`ifdef C17_FAULT_INJ_EN
        ,
        .inj_en (inj2)
`endif
    );

    // Reference signature: written directly from the c17 gate equations.
    function automatic logic [15:0] model_sig(input logic [31:0] seed, input int n, input int ch);
        logic [31:0] l;
        logic [15:0] m;
        logic [15:0] r;
        logic a1, a2, a3, a6, a7, g10, g11, g16, g19;
        l = (seed == 32'd0) ? 32'd1 : seed;
        m = 16'd0;
        for (int i = 0; i < n; i++) begin
            r = 16'd0;
            for (int c = 0; c < ch; c++) begin
                a1 = l[5*c]; a2 = l[5*c+1]; a3 = l[5*c+2]; a6 = l[5*c+3]; a7 = l[5*c+4];
                g10 = !(a1 && a3);
                g11 = !(a3 && a6);
                g16 = !(a2 && g11);
                g19 = !(g11 && a7);
                r[2*c]   = !(g10 && g16);
                r[2*c+1] = !(g16 && g19);
            end
            m = ({1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000)) ^ r;
            l = {1'b0, l[31:1]} ^ (l[0] ? 32'h80200003 : 32'h00000000);
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        u_if0.start = 1'b0;
        u_if1.start = 1'b0;
        u_if2.start = 1'b0;
        rst = 1'b1;
        step();
        step();
        nvec++;
        if ({u_if0.busy, u_if0.done, u_if0.pass} !== 3'b000) begin
            nerr++; $display("FAIL reset_flags got=%b want=000", {u_if0.busy, u_if0.done, u_if0.pass});
        end
        nvec++;
        if (u_if0.signature !== 16'h0000) begin
            nerr++; $display("FAIL reset_sig got=%h want=0000", u_if0.signature);
        end
        nvec++;
        if (u_if0.pat_cnt !== 16'd0) begin
            nerr++; $display("FAIL reset_cnt got=%0d want=0", u_if0.pat_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_pattern();
        u_if1.start = 1'b1;
        step();
        u_if1.start = 1'b0;
        nvec++;
        if ({u_if1.busy, u_if1.done} !== 2'b10) begin
            nerr++; $display("FAIL single_run busy/done got=%b want=10", {u_if1.busy, u_if1.done});
        end
        step();
        nvec++;
        if ({u_if1.busy, u_if1.done, u_if1.pass} !== 3'b011) begin
            nerr++; $display("FAIL single_done busy/done/pass got=%b want=011", {u_if1.busy, u_if1.done, u_if1.pass});
        end
        nvec++;
        if (u_if1.signature !== 16'h0001) begin
            nerr++; $display("FAIL single_sig got=%h want=0001", u_if1.signature);
        end
        nvec++;
        if (u_if1.pat_cnt !== 16'd1) begin
            nerr++; $display("FAIL single_cnt got=%0d want=1", u_if1.pat_cnt);
        end
        step();
        nvec++;
        if ({u_if1.done, u_if1.signature} !== {1'b1, 16'h0001}) begin
            nerr++; $display("FAIL single_hold done/sig got=%b/%h want=1/0001", u_if1.done, u_if1.signature);
        end
    endtask

    task automatic test_seed_one();
        u_if2.start = 1'b1;
        step();
        u_if2.start = 1'b0;
        step();
        nvec++;
        if ({u_if2.done, u_if2.pass, u_if2.signature} !== {1'b1, 1'b1, 16'h0000}) begin
            nerr++; $display("FAIL seed1 done/pass/sig got=%b/%b/%h want=1/1/0000",
                             u_if2.done, u_if2.pass, u_if2.signature);
        end
    endtask

    // Runs u_dut0 to completion; optionally pulses start at RUN cycle 10.
    task automatic run_default(input bit pulse_mid, output int busy_cycles);
        busy_cycles = 0;
        u_if0.start = 1'b1;
        step();
        u_if0.start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!u_if0.busy) break;
            busy_cycles++;
            u_if0.start = (pulse_mid && busy_cycles == 10);
            step();
        end
        u_if0.start = 1'b0;
    endtask

    task automatic test_long_run();
        int          cyc;
        logic [15:0] exp_sig;
        logic [15:0] sig1;
        exp_sig = model_sig(32'h0000ACE1, 255, 4);
        run_default(1'b1, cyc);
        nvec++;
        if (cyc !== 255) begin
            nerr++; $display("FAIL long_busy_cycles got=%0d want=255", cyc);
        end
        nvec++;
        if ({u_if0.done, u_if0.pat_cnt} !== {1'b1, 16'd255}) begin
            nerr++; $display("FAIL long_done done/cnt got=%b/%0d want=1/255", u_if0.done, u_if0.pat_cnt);
        end
        nvec++;
        if (u_if0.signature !== exp_sig) begin
            nerr++; $display("FAIL long_sig got=%h want=%h", u_if0.signature, exp_sig);
        end
        nvec++;
        if (u_if0.pass !== (exp_sig == 16'h0000)) begin
            nerr++; $display("FAIL long_pass got=%b want=%b", u_if0.pass, (exp_sig == 16'h0000));
        end
        sig1 = u_if0.signature;
        // Restart from DONE: reload must clear the counter and signature.
        u_if0.start = 1'b1;
        step();
        u_if0.start = 1'b0;
        nvec++;
        if ({u_if0.busy, u_if0.done, u_if0.pat_cnt, u_if0.signature} !== {1'b1, 1'b0, 16'd0, 16'h0000}) begin
            nerr++; $display("FAIL restart_load busy/done/cnt/sig got=%b/%b/%0d/%h want=1/0/0/0000",
                             u_if0.busy, u_if0.done, u_if0.pat_cnt, u_if0.signature);
        end
        cyc = 1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!u_if0.busy) break;
            cyc++;
        end
        nvec++;
        if ({u_if0.done, u_if0.signature} !== {1'b1, exp_sig}) begin
            nerr++; $display("FAIL restart_sig done/sig got=%b/%h want=1/%h (run1 %h)",
                             u_if0.done, u_if0.signature, exp_sig, sig1);
        end
        nvec++;
        if (cyc !== 255) begin
            nerr++; $display("FAIL restart_busy_cycles got=%0d want=255", cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seen;
        u_if1.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            seen[3-i] = u_if1.busy && !u_if1.done;
        end
        u_if1.start = 1'b0;
        nvec++;
        if (seen !== 4'b1010) begin
            nerr++; $display("FAIL back_to_back busy pattern got=%b want=1010", seen);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int dones;
        u_if0.start = 1'b1;
        step();
        u_if0.start = 1'b0;
        for (int i = 1; i < 100; i++) step();
        nvec++;
        if ({u_if0.busy, u_if0.pat_cnt} !== {1'b1, 16'd99}) begin
            nerr++; $display("FAIL midrun busy/cnt got=%b/%0d want=1/99", u_if0.busy, u_if0.pat_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        nvec++;
        if ({u_if0.busy, u_if0.done, u_if0.pass, u_if0.signature, u_if0.pat_cnt} !== 35'd0) begin
            nerr++; $display("FAIL midrun_reset busy/done/pass/sig/cnt got=%b/%b/%b/%h/%0d want=0/0/0/0000/0",
                             u_if0.busy, u_if0.done, u_if0.pass, u_if0.signature, u_if0.pat_cnt);
        end
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (u_if0.done || u_if0.busy) dones++;
        end
        nvec++;
        if (dones !== 0) begin
            nerr++; $display("FAIL midrun_no_done activity cycles got=%0d want=0", dones);
        end
    endtask

`ifdef C17_FAULT_INJ_EN
    task automatic test_fault_inj();
        inj1 = 1'b1;
        u_if1.start = 1'b1;
        step();
        u_if1.start = 1'b0;
        step();
        nvec++;
        if ({u_if1.done, u_if1.pass, u_if1.signature} !== {1'b1, 1'b0, 16'h0003}) begin
            nerr++; $display("FAIL fault_inj done/pass/sig got=%b/%b/%h want=1/0/0003",
                             u_if1.done, u_if1.pass, u_if1.signature);
        end
        inj1 = 1'b0;
    endtask
`endif

    initial begin
        u_if0.start = 1'b0;
        u_if1.start = 1'b0;
        u_if2.start = 1'b0;
        test_reset();
        test_single_pattern();
        test_seed_one();
        test_long_run();
        test_back_to_back();
        test_reset_mid_run();
`ifdef C17_FAULT_INJ_EN
        test_fault_inj();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
